// File: rtl/bkm_control_step_stimulus_pkg.sv
// Shared definitions for the bkm_control_step stimulus generator:
// digit codes, FSM state encoding, LFSR tap mask and default seed.
package bkm_control_step_stimulus_pkg;

  // Width of the iteration index tb_n
  localparam int LOG2N = 4;

  // Signed-digit codes driven on tb_d_u_n / tb_d_v_n (2'b10 is never driven)
  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b01;
  localparam logic [1:0] DIG_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Fibonacci taps 64,63,61,60 expressed as a mask on state bits 63,62,60,59
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0000_0001;

endpackage

// File: rtl/bkm_control_step_stimulus_lfsr.sv
// 64-bit Fibonacci LFSR: shifts left, feedback into bit 0.
// load (or srst) restores the seed; enable advances one step.
module bkm_control_step_stimulus_lfsr
  import bkm_control_step_stimulus_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        load,
  input  logic [63:0] seed,
  output logic [63:0] state
);

  // Seed on reset/load, otherwise one step per enable
  always_ff @(posedge clk) begin
    if (srst || load) begin
      state <= seed;
    end else if (enable) begin
      state <= {state[62:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/bkm_control_step_stimulus.sv
// Stimulus generator for bkm_control_step. Issues one vector per enabled
// cycle while running, delays stim_valid by LAT to form chk_enable, and
// reports done once the last checker enable has fired.
// Optional: define BKM_STIM_CORNERS_EN to prepend four fixed corner vectors.
module bkm_control_step_stimulus
  import bkm_control_step_stimulus_pkg::*;
#(
  parameter int          W       = 64,
  parameter int          LAT     = 1,
  parameter int          NUM_VEC = 1024,
  parameter logic [63:0] SEED    = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_u_n,
  output logic [1:0]       tb_d_v_n,
  output logic [W-1:0]     tb_u_n,
  output logic [W-1:0]     tb_v_n,
  output logic             stim_valid,
  output logic             chk_enable,
  output logic [31:0]      vec_cnt,
  output logic             busy,
  output logic             done
);

  localparam int               DCW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [31:0]      NUM_VEC_C = 32'(NUM_VEC);
  localparam logic [LOG2N-1:0] N_LAST    = '1;

  function automatic logic [1:0] dig_map(input logic [1:0] raw);
    return (raw == 2'b10) ? DIG_ZERO : raw;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == '1) ? x : x + 32'd1;
  endfunction

  state_t         state, state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic [63:0]    lfsr;
  logic           issue_first, issue_next, issue, corner;
  logic           lfsr_adv, lfsr_load;
  logic [W-1:0]   vec_u, vec_v;
  logic [1:0]     vec_du, vec_dv;
  logic [LAT-1:0] vld_p;

  // Next state and issue decisions
  always_comb begin
    state_nxt   = state;
    issue_first = 1'b0;
    issue_next  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (NUM_VEC == 0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt   = ST_RUN;
            issue_first = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (vec_cnt >= NUM_VEC_C) state_nxt = ST_DRAIN;
        else                      issue_next = 1'b1;
      end
      ST_DRAIN: begin
        if (drain_cnt == DCW'(LAT - 1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign issue = issue_first | issue_next;

`ifdef BKM_STIM_CORNERS_EN
  logic [31:0] vidx;
  assign vidx   = issue_first ? 32'd0 : vec_cnt;
  assign corner = (vidx < 32'd4);
`else
  assign corner = 1'b0;
`endif

  // Corner vectors do not consume LFSR states; entering DONE rearms the seed
  assign lfsr_adv  = issue & ~corner;
  assign lfsr_load = (state_nxt == ST_DONE) && (state != ST_DONE);

  bkm_control_step_stimulus_lfsr u_lfsr (
    .clk    (clk),
    .srst   (srst),
    .enable (enable & lfsr_adv),
    .load   (enable & lfsr_load),
    .seed   (SEED),
    .state  (lfsr)
  );

  // Candidate vector for this issue: LFSR slice or fixed corner
  always_comb begin
    vec_u  = lfsr[W-1:0];
    vec_v  = lfsr[63:64-W];
    vec_du = dig_map(lfsr[1:0]);
    vec_dv = dig_map(lfsr[3:2]);
`ifdef BKM_STIM_CORNERS_EN
    if (corner) begin
      case (vidx[1:0])
        2'd0: begin vec_u = '0; vec_v = '0; vec_du = DIG_ZERO; vec_dv = DIG_ZERO; end
        2'd1: begin vec_u = '1; vec_v = '1; vec_du = DIG_POS;  vec_dv = DIG_POS;  end
        2'd2: begin
          vec_u  = W'(1) << (W - 1);
          vec_v  = W'(1) << (W - 1);
          vec_du = DIG_NEG;
          vec_dv = DIG_NEG;
        end
        default: begin vec_u = W'(1); vec_v = '1; vec_du = DIG_POS; vec_dv = DIG_NEG; end
      endcase
    end
`endif
  end

  // State, vector outputs, sweeps, counters and the chk_enable delay pipe
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      stim_valid <= 1'b0;
      vld_p      <= '0;
      vec_cnt    <= '0;
      tb_u_n     <= '0;
      tb_v_n     <= '0;
      tb_d_u_n   <= DIG_ZERO;
      tb_d_v_n   <= DIG_ZERO;
      tb_n       <= '0;
      tb_format  <= '0;
      tb_mode    <= 1'b0;
    end else if (enable) begin
      state      <= state_nxt;
      drain_cnt  <= (state == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;
      stim_valid <= issue;
      vld_p      <= (vld_p << 1) | LAT'(stim_valid);
      if ((state == ST_IDLE || state == ST_DONE) && start) begin
        vec_cnt <= (NUM_VEC == 0) ? 32'd0 : 32'd1;
      end else if (issue_next) begin
        vec_cnt <= sat_inc(vec_cnt);
      end
      if (issue) begin
        tb_u_n   <= vec_u;
        tb_v_n   <= vec_v;
        tb_d_u_n <= vec_du;
        tb_d_v_n <= vec_dv;
      end
      if (issue_first) begin
        tb_n      <= '0;
        tb_format <= '0;
        tb_mode   <= 1'b0;
      end else if (issue_next) begin
        tb_n <= tb_n + LOG2N'(1);
        if (tb_n == N_LAST) begin
          tb_format <= tb_format + 2'd1;
          if (tb_format == 2'd3) tb_mode <= ~tb_mode;
        end
      end
    end
  end

  assign chk_enable = vld_p[LAT-1];
  assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_bkm_control_step_stimulus.sv
// Bench for bkm_control_step_stimulus: three instances (NUM_VEC=8/LAT=3/W=64,
// NUM_VEC=17/LAT=1/W=16, NUM_VEC=0/LAT=2/W=8) share clk/srst/enable/start.
// A run-level model predicts every output each cycle; vector contents are
// derived from the vector index alone.
module tb_bkm_control_step_stimulus;
  import bkm_control_step_stimulus_pkg::*;

  localparam int NPER = 1 << LOG2N;

  logic clk = 1'b0;
  logic srst, enable, start;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  int p_w[3]   = '{64, 16, 8};
  int p_lat[3] = '{3, 1, 2};
  int p_nv[3]  = '{8, 17, 0};

  // DUT A
  logic mode_a, sv_a, ce_a, busy_a, done_a;
  logic [1:0] fmt_a, du_a, dv_a;
  logic [LOG2N-1:0] n_a;
  logic [63:0] u_a, v_a;
  logic [31:0] cnt_a;
  // DUT B
  logic mode_b, sv_b, ce_b, busy_b, done_b;
  logic [1:0] fmt_b, du_b, dv_b;
  logic [LOG2N-1:0] n_b;
  logic [15:0] u_b, v_b;
  logic [31:0] cnt_b;
  // DUT C
  logic mode_c, sv_c, ce_c, busy_c, done_c;
  logic [1:0] fmt_c, du_c, dv_c;
  logic [LOG2N-1:0] n_c;
  logic [7:0] u_c, v_c;
  logic [31:0] cnt_c;

  bkm_control_step_stimulus #(.W(64), .LAT(3), .NUM_VEC(8)) dut_a (
    .clk(clk), .srst(srst), .enable(enable), .start(start),
    .tb_mode(mode_a), .tb_format(fmt_a), .tb_n(n_a), .tb_d_u_n(du_a), .tb_d_v_n(dv_a),
    .tb_u_n(u_a), .tb_v_n(v_a), .stim_valid(sv_a), .chk_enable(ce_a),
    .vec_cnt(cnt_a), .busy(busy_a), .done(done_a));

  bkm_control_step_stimulus #(.W(16), .LAT(1), .NUM_VEC(NPER + 1)) dut_b (
    .clk(clk), .srst(srst), .enable(enable), .start(start),
    .tb_mode(mode_b), .tb_format(fmt_b), .tb_n(n_b), .tb_d_u_n(du_b), .tb_d_v_n(dv_b),
    .tb_u_n(u_b), .tb_v_n(v_b), .stim_valid(sv_b), .chk_enable(ce_b),
    .vec_cnt(cnt_b), .busy(busy_b), .done(done_b));

  bkm_control_step_stimulus #(.W(8), .LAT(2), .NUM_VEC(0)) dut_c (
    .clk(clk), .srst(srst), .enable(enable), .start(start),
    .tb_mode(mode_c), .tb_format(fmt_c), .tb_n(n_c), .tb_d_u_n(du_c), .tb_d_v_n(dv_c),
    .tb_u_n(u_c), .tb_v_n(v_c), .stim_valid(sv_c), .chk_enable(ce_c),
    .vec_cnt(cnt_c), .busy(busy_c), .done(done_c));

  // ---------------- reference model ----------------
  logic [63:0] seq [0:63];   // LFSR state sequence starting at the seed

  typedef struct {
    logic [63:0] u, v;
    logic [1:0]  du, dv;
    int          n, fmt, mode;
  } vec_t;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    int taps[4] = '{64, 63, 61, 60};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i] - 1];
    return {s[62:0], fb};
  endfunction

  function automatic logic [1:0] digit(input logic [1:0] raw);
    return (raw == 2'b10) ? 2'b00 : raw;
  endfunction

  function automatic vec_t vec_of(input int w, input int idx);
    vec_t r;
    logic [63:0] s, m;
    m      = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r.n    = idx % NPER;
    r.fmt  = (idx / NPER) % 4;
    r.mode = (idx / (NPER * 4)) % 2;
`ifdef BKM_STIM_CORNERS_EN
    if (idx < 4) begin
      case (idx)
        0: begin r.u = 0; r.v = 0; r.du = 2'b00; r.dv = 2'b00; end
        1: begin r.u = m; r.v = m; r.du = 2'b01; r.dv = 2'b01; end
        2: begin r.u = 64'd1 << (w - 1); r.v = 64'd1 << (w - 1); r.du = 2'b11; r.dv = 2'b11; end
        default: begin r.u = 64'd1; r.v = m; r.du = 2'b01; r.dv = 2'b11; end
      endcase
      return r;
    end
    s = seq[idx - 4];
`else
    s = seq[idx];
`endif
    r.u  = s & m;
    r.v  = s >> (64 - w);
    r.du = digit(s[1:0]);
    r.dv = digit(s[3:2]);
    return r;
  endfunction

  // Run-level state per instance: phase 0 idle, 1 issuing, 2 draining, 3 done
  int ph[3], k[3], dc[3];
  bit sv_m[3], have[3];
  bit hist[3][8];           // hist[i][j]: stim_valid j+1 enabled cycles ago

  task automatic model_step(input int i);
    if (srst) begin
      ph[i] = 0; k[i] = 0; dc[i] = 0; sv_m[i] = 0; have[i] = 0;
      for (int j = 0; j < 8; j++) hist[i][j] = 0;
    end else if (enable) begin
      for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = sv_m[i];
      case (ph[i])
        0, 3: if (start) begin
          k[i] = 0;
          if (p_nv[i] == 0) ph[i] = 3;
          else begin ph[i] = 1; k[i] = 1; have[i] = 1; sv_m[i] = 1; end
        end
        1: if (k[i] == p_nv[i]) begin ph[i] = 2; dc[i] = 0; sv_m[i] = 0; end
           else k[i]++;
        default: begin dc[i]++; if (dc[i] == p_lat[i]) ph[i] = 3; end
      endcase
    end
  endtask

  always @(posedge clk) for (int i = 0; i < 3; i++) model_step(i);

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h want %h", name, i, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input logic [63:0] u, input logic [63:0] v,
                            input logic [1:0] du, input logic [1:0] dv,
                            input logic [LOG2N-1:0] n, input logic [1:0] fmt, input logic mode,
                            input logic sv, input logic ce, input logic [31:0] cnt,
                            input logic bsy, input logic dn);
    vec_t e;
    if (have[i]) e = vec_of(p_w[i], k[i] - 1);
    else begin e.u = 0; e.v = 0; e.du = 0; e.dv = 0; e.n = 0; e.fmt = 0; e.mode = 0; end
    chk("u", i, u, e.u);
    chk("v", i, v, e.v);
    chk("d_u", i, 64'(du), 64'(e.du));
    chk("d_v", i, 64'(dv), 64'(e.dv));
    chk("n", i, 64'(n), 64'(e.n));
    chk("format", i, 64'(fmt), 64'(e.fmt));
    chk("mode", i, 64'(mode), 64'(e.mode));
    chk("stim_valid", i, 64'(sv), 64'(sv_m[i]));
    chk("chk_enable", i, 64'(ce), 64'(hist[i][p_lat[i] - 1]));
    chk("vec_cnt", i, 64'(cnt), 64'(k[i]));
    chk("busy", i, 64'(bsy), 64'(ph[i] == 1 || ph[i] == 2));
    chk("done", i, 64'(dn), 64'(ph[i] == 3));
    chk("digit_not_10", i, 64'((du == 2'b10) || (dv == 2'b10)), 64'd0);
  endtask

  always @(negedge clk) if (mon_on) begin
    check_inst(0, u_a, v_a, du_a, dv_a, n_a, fmt_a, mode_a, sv_a, ce_a, cnt_a, busy_a, done_a);
    check_inst(1, 64'(u_b), 64'(v_b), du_b, dv_b, n_b, fmt_b, mode_b, sv_b, ce_b, cnt_b, busy_b, done_b);
    check_inst(2, 64'(u_c), 64'(v_c), du_c, dv_c, n_c, fmt_c, mode_c, sv_c, ce_c, cnt_c, busy_c, done_c);
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] get_cnt(input int i);
    return (i == 0) ? cnt_a : (i == 1) ? cnt_b : cnt_c;
  endfunction

  task automatic wait_cnt(input int i, input int val, input int budget);
    int c = 0;
    while (get_cnt(i) != 32'(val) && c < budget) begin @(posedge clk); #1; c++; end
    chk("wait_vec_cnt", i, 64'(get_cnt(i)), 64'(val));
  endtask

  task automatic wait_all_done(input int budget);
    int c = 0;
    while (!(done_a && done_b && done_c) && c < budget) begin @(posedge clk); #1; c++; end
    chk("wait_done", 0, 64'({done_a, done_b, done_c}), 64'b111);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

`ifdef BKM_STIM_CORNERS_EN
  localparam int FRZ_CNT = 4;
`else
  localparam int FRZ_CNT = 2;
`endif

  initial begin
    srst = 1'b1; enable = 1'b1; start = 1'b0;
    seq[0] = DEFAULT_SEED;
    for (int j = 1; j < 64; j++) seq[j] = lfsr_step(seq[j-1]);
    // Hand-derived first LFSR steps from the default seed
    chk("seq1", 0, seq[1], 64'h0001_59C2_0000_0002);
    chk("seq2", 0, seq[2], 64'h0002_B384_0000_0004);

    @(posedge clk); #1; mon_on = 1'b1;
    @(posedge clk); #1; srst = 1'b0;
    chk("reset_cnt", 0, 64'(cnt_a), 64'd0);
    chk("reset_done", 0, 64'(done_a | busy_a | sv_a | ce_a), 64'd0);

    // Run 1 with a 5-cycle enable freeze
    pulse_start();
    wait_cnt(0, 2, 10);
`ifdef BKM_STIM_CORNERS_EN
    chk("pin_a_v1_u", 0, u_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_a_v1_du", 0, 64'(du_a), 64'd1);
    wait_cnt(1, 4, 10);
    chk("pin_b_v3_u", 1, 64'(u_b), 64'h0001);
    chk("pin_b_v3_v", 1, 64'(v_b), 64'hFFFF);
`else
    chk("pin_a_v1_u", 0, u_a, 64'h0001_59C2_0000_0002);
    chk("pin_a_v1_du", 0, 64'(du_a), 64'd0);
`endif
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("freeze_cnt", 0, 64'(cnt_a), 64'(FRZ_CNT));
    chk("freeze_valid", 0, 64'(sv_a), 64'd1);
    enable = 1'b1;
    wait_cnt(1, NPER + 1, 40);
    chk("wrap_n", 1, 64'(n_b), 64'd0);
    chk("wrap_format", 1, 64'(fmt_b), 64'd1);
    wait_all_done(60);
    chk("c_done_no_vec", 2, 64'(cnt_c), 64'd0);

    // Run 2 directly from DONE
    pulse_start();
    wait_all_done(60);

    // Run 3 aborted by srst, then a fresh run
    pulse_start();
    wait_cnt(0, 3, 10);
    srst = 1'b1; @(posedge clk); #1; srst = 1'b0;
    chk("abort_cnt", 0, 64'(cnt_a), 64'd0);
    chk("abort_u", 0, u_a, 64'd0);
    chk("abort_busy", 0, 64'(busy_a | done_a), 64'd0);
    pulse_start();
    chk("rerun_u0", 0, u_a, DEFAULT_SEED
`ifdef BKM_STIM_CORNERS_EN
      & 64'd0
`endif
    );
    wait_all_done(60);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
